ex_stage_muldiv: RTL and testbench
==================================

// Module: ex_stage_muldiv
// PURPOSE
//  Execute stage plus the EX/MEM pipeline register. It consumes the ID/EX register outputs,
//  runs ALU control and the ALU, computes the branch target and selects the write register.
//  Results are registered toward MEM. An iterative unsigned multiply/divide engine with HI/LO
//  registers is included; it raises stall_o to freeze the PC, IF/ID and ID/EX while it is busy.
// PARAMETERS
//  DW        32  datapath width; the mul/div engine iterates DW times
//  MD_ENABLE 1   0 = multu/divu treated as NOP, and stall_o is tied to 0
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous, active-high reset
//  RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in, RegDst_in, ALUSrc_in
//               in   1   ID/EX control bits
//  ALUop_in     in   2   00 add, 01 sub, 10 R-type (decode funct), 11 or (ori)
//  pc_incr      in   DW  PC+4 of the instruction
//  shamt, funct in   5,6 instruction fields
//  RD1, RD2     in   DW  register operands
//  immed        in   DW  sign-extended immediate
//  rt, rd       in   5   destination candidates
//  stall_o      out  1   freezes upstream (drives the ID/EX enReg low); combinational
//  RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out
//               out  1   EX/MEM control
//  Zero_out     out  1   ALU result == 0
//  ALUResult_out out DW  ALU / mfhi / mflo result
//  btarget_out  out  DW  pc_incr + (immed << 2), truncated to DW
//  storeData_out out DW  RD2 (sw data)
//  wrReg_out    out  5   RegDst_in ? rd : rt
// BEHAVIOUR
//  - Reset: all outputs are 0 at the first edge with rst=1. HI=LO=0 and FSM=IDLE.
//    A reset mid-operation aborts the mul/div engine and leaves HI/LO at 0.
//  - ALUop 10 funct decode:
//      20 add, 22 sub, 24 and, 25 or, 2A slt (signed), 00 sll RD2<<shamt, 02 srl RD2>>shamt,
//      10 mfhi, 12 mflo, 19 multu, 1B divu.
//    Any other funct gives result 0. Add/sub wrap modulo 2^DW with no overflow trap.
//  - Operand B = ALUSrc_in ? immed : RD2.
//  - Latency 1: the EX/MEM register captures on every edge where stall_o=0.
//  - When stall_o=1, the EX/MEM register loads a bubble: all control outputs 0, data don't-care
//    (driven 0).
//  - mul/div FSM:
//      IDLE: if ALUop=10 and funct is 19/1B, then stall_o=1, latch operands, cnt<=0, go to BUSY.
//            Otherwise stall_o=0.
//      BUSY: stall_o=1. One shift-add (multu) or restoring-subtract (divu) step per cycle; cnt++.
//            At cnt==DW-1: write HI/LO, go to DONE.
//      DONE: stall_o=0. The held multu/divu passes to EX/MEM with RegWrite_out forced to 0.
//            Go to IDLE unconditionally, so the held instruction never restarts the engine.
//    stall_o is high for exactly DW+1 cycles per multu/divu.
//  - multu: {HI,LO} = RD1*RD2 as an unsigned 2DW-bit product.
//  - divu: LO = quotient, HI = remainder.
//  - divu by 0: LO = all ones, HI = RD1. No exception.
//  - mfhi/mflo read the HI/LO value as of the current cycle. Stall guarantees that any earlier
//    multu/divu has completed.
//  - Back-to-back multu/divu: the second enters IDLE after DONE and restarts normally.
// TESTING
//  1 Reset: hold rst 2 cycles with random inputs -> every output 0 and stall_o=0.
//  2 R-type sequence:
//      add 7+5 -> ALUResult_out=12, Zero_out=0
//      sub 5-5 -> Zero_out=1
//      slt -1<1 -> 1
//      sll 1,shamt 31 -> 0x80000000
//    Each result appears 1 cycle after presentation.
//  3 Branch: pc_incr=0x100, immed=0xFFFFFFFF, ALUop=01, RD1=RD2 -> btarget_out=0xFC, Zero_out=1,
//    Branch_out=1.
//  4 multu 0xFFFFFFFF*2 -> stall_o high 33 cycles, bubbles on EX/MEM. Then mflo -> 0xFFFFFFFE,
//    and mfhi -> 1.
//  5 divu 100/7 -> LO=14, HI=2. divu 9/0 -> LO=0xFFFFFFFF, HI=9.
//  6 Assert rst in the 10th BUSY cycle -> next cycle IDLE, stall_o=0, HI=LO=0, then mflo returns 0.

Source files
------------

// File: rtl/ex_stage_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_muldiv
// Purpose  : Execute stage with the EX/MEM pipeline register. Contains ALU
//            control, the ALU, the branch-target adder and the write-register
//            mux. Also holds an iterative unsigned multiply/divide engine with
//            HI/LO registers that stalls the upstream pipeline while it runs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   *_in control bits   ID/EX control (RegWrite, MemtoReg, MemRead, MemWrite,
//                       Branch, RegDst, ALUSrc), ALUop_in[1:0]
//   pc_incr, RD1, RD2,  datapath inputs (DW bits)
//   immed
//   shamt, funct        instruction fields (5 / 6 bits)
//   rt, rd              destination register candidates
//   stall_o             combinational; freezes PC, IF/ID and ID/EX
//   *_out               EX/MEM register outputs (control, Zero, ALU result,
//                       branch target, store data, write register)
// ============================================================================
module ex_stage_muldiv #(
  parameter int DW        = 32,
  parameter bit MD_ENABLE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWrite_in,
  input  logic          MemtoReg_in,
  input  logic          MemRead_in,
  input  logic          MemWrite_in,
  input  logic          Branch_in,
  input  logic          RegDst_in,
  input  logic          ALUSrc_in,
  input  logic [1:0]    ALUop_in,
  input  logic [DW-1:0] pc_incr,
  input  logic [4:0]    shamt,
  input  logic [5:0]    funct,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2,
  input  logic [DW-1:0] immed,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  output logic          stall_o,
  output logic          RegWrite_out,
  output logic          MemtoReg_out,
  output logic          MemRead_out,
  output logic          MemWrite_out,
  output logic          Branch_out,
  output logic          Zero_out,
  output logic [DW-1:0] ALUResult_out,
  output logic [DW-1:0] btarget_out,
  output logic [DW-1:0] storeData_out,
  output logic [4:0]    wrReg_out
);

  localparam logic [5:0] c_F_SLL   = 6'h00;
  localparam logic [5:0] c_F_SRL   = 6'h02;
  localparam logic [5:0] c_F_MFHI  = 6'h10;
  localparam logic [5:0] c_F_MFLO  = 6'h12;
  localparam logic [5:0] c_F_MULTU = 6'h19;
  localparam logic [5:0] c_F_DIVU  = 6'h1B;
  localparam logic [5:0] c_F_ADD   = 6'h20;
  localparam logic [5:0] c_F_SUB   = 6'h22;
  localparam logic [5:0] c_F_AND   = 6'h24;
  localparam logic [5:0] c_F_OR    = 6'h25;
  localparam logic [5:0] c_F_SLT   = 6'h2A;

  localparam int            c_CW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_start;
  logic [c_CW-1:0] r_cnt;
  logic            r_is_div;
  logic [DW-1:0]   r_acc;     // partial product high half / partial remainder
  logic [DW-1:0]   r_mq;      // multiplier shifting into low product / dividend -> quotient
  logic [DW-1:0]   r_opb;     // multiplicand / divisor
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;

  logic [DW-1:0]   w_opb;
  logic [DW-1:0]   w_res;
  logic            w_is_md;
  logic [DW-1:0]   w_btarget;

  logic [DW:0]     w_mul_sum;
  logic [DW:0]     w_div_sh;
  logic [DW:0]     w_div_diff;
  logic            w_div_ge;
  logic [DW-1:0]   w_acc_nxt;
  logic [DW-1:0]   w_mq_nxt;

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  assign w_opb     = ALUSrc_in ? immed : RD2;
  assign w_is_md   = (ALUop_in == 2'b10) && ((funct == c_F_MULTU) || (funct == c_F_DIVU));
  assign w_btarget = pc_incr + (immed << 2);

  always_comb begin
    w_res = '0;
    case (ALUop_in)
      2'b00: w_res = RD1 + w_opb;
      2'b01: w_res = RD1 - w_opb;
      2'b11: w_res = RD1 | w_opb;
      default: begin
        case (funct)
          c_F_ADD:  w_res = RD1 + w_opb;
          c_F_SUB:  w_res = RD1 - w_opb;
          c_F_AND:  w_res = RD1 & w_opb;
          c_F_OR:   w_res = RD1 | w_opb;
          c_F_SLT:  w_res = {{(DW-1){1'b0}}, ($signed(RD1) < $signed(w_opb))};
          c_F_SLL:  w_res = RD2 << shamt;
          c_F_SRL:  w_res = RD2 >> shamt;
          c_F_MFHI: w_res = r_hi;
          c_F_MFLO: w_res = r_lo;
          default:  w_res = '0;
        endcase
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Multiply / divide engine
  // --------------------------------------------------------------------------
  // Shift-add multiply: add multiplicand when the multiplier LSB is set, then
  // shift {acc, mq} right by one with the carry entering at the top.
  assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opb} : {(DW+1){1'b0}});

  // Restoring divide: shift the next dividend bit into the remainder and try a
  // subtract. The remainder stays below the divisor, so the difference's top
  // bit is set exactly when the trial subtract borrowed. A zero divisor never
  // borrows, which yields an all-ones quotient and the dividend as remainder.
  assign w_div_sh   = {r_acc, r_mq[DW-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_opb};
  assign w_div_ge   = ~w_div_diff[DW];

  always_comb begin
    if (r_is_div) begin
      w_acc_nxt = w_div_ge ? w_div_diff[DW-1:0] : w_div_sh[DW-1:0];
      w_mq_nxt  = {r_mq[DW-2:0], w_div_ge};
    end else begin
      w_acc_nxt = w_mul_sum[DW:1];
      w_mq_nxt  = {w_mul_sum[0], r_mq[DW-1:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MD_ENABLE && w_is_md && !rst) begin
          stall_o     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      // The held instruction leaves ID/EX this cycle; returning to IDLE
      // unconditionally keeps it from re-launching the engine.
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_acc    <= '0;
        r_mq     <= RD1;
        r_opb    <= RD2;
        r_is_div <= (funct == c_F_DIVU);
        r_cnt    <= '0;
      end else if (r_state == S_BUSY) begin
        r_acc <= w_acc_nxt;
        r_mq  <= w_mq_nxt;
        r_cnt <= r_cnt + c_CW'(1);
        if (r_cnt == c_CNT_LAST) begin
          r_hi <= w_acc_nxt;
          r_lo <= w_mq_nxt;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // EX/MEM pipeline register; a stall inserts a bubble
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || stall_o) begin
      RegWrite_out  <= 1'b0;
      MemtoReg_out  <= 1'b0;
      MemRead_out   <= 1'b0;
      MemWrite_out  <= 1'b0;
      Branch_out    <= 1'b0;
      Zero_out      <= 1'b0;
      ALUResult_out <= '0;
      btarget_out   <= '0;
      storeData_out <= '0;
      wrReg_out     <= '0;
    end else begin
      // multu/divu write only HI/LO, never the register file
      RegWrite_out  <= RegWrite_in & ~w_is_md;
      MemtoReg_out  <= MemtoReg_in;
      MemRead_out   <= MemRead_in;
      MemWrite_out  <= MemWrite_in;
      Branch_out    <= Branch_in;
      Zero_out      <= (w_res == '0);
      ALUResult_out <= w_res;
      btarget_out   <= w_btarget;
      storeData_out <= RD2;
      wrReg_out     <= RegDst_in ? rd : rt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_muldiv
// Purpose  : Self-checking bench for ex_stage_muldiv. Table-driven ALU and
//            branch vectors, plus hand-written mul/div and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage_muldiv;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
  logic          Branch_in, RegDst_in, ALUSrc_in;
  logic [1:0]    ALUop_in;
  logic [DW-1:0] pc_incr;
  logic [4:0]    shamt;
  logic [5:0]    funct;
  logic [DW-1:0] RD1, RD2, immed;
  logic [4:0]    rt, rd;
  logic          stall_o;
  logic          RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out;
  logic          Zero_out;
  logic [DW-1:0] ALUResult_out, btarget_out, storeData_out;
  logic [4:0]    wrReg_out;

  int checks = 0;
  int errors = 0;

  ex_stage_muldiv #(.DW(DW), .MD_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .Branch_in(Branch_in), .RegDst_in(RegDst_in),
    .ALUSrc_in(ALUSrc_in), .ALUop_in(ALUop_in), .pc_incr(pc_incr), .shamt(shamt),
    .funct(funct), .RD1(RD1), .RD2(RD2), .immed(immed), .rt(rt), .rd(rd),
    .stall_o(stall_o), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .Branch_out(Branch_out),
    .Zero_out(Zero_out), .ALUResult_out(ALUResult_out), .btarget_out(btarget_out),
    .storeData_out(storeData_out), .wrReg_out(wrReg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic        alusrc;
    logic        regdst;
    logic        rw;
    logic        br;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] e_bt;
    logic [4:0]  e_wr;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                              input logic alusrc, input logic regdst, input logic rw, input logic br,
                              input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [31:0] e_res, input logic e_zero,
                              input logic [31:0] e_bt, input logic [4:0] e_wr);
    vec_t v;
    v.op = op; v.fn = fn; v.sh = sh; v.alusrc = alusrc; v.regdst = regdst; v.rw = rw; v.br = br;
    v.pc = pc; v.a = a; v.b = b; v.imm = imm;
    v.e_res = e_res; v.e_zero = e_zero; v.e_bt = e_bt; v.e_wr = e_wr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
    Branch_in = 0; RegDst_in = 0; ALUSrc_in = 0; ALUop_in = 2'b00;
    pc_incr = '0; shamt = '0; funct = '0; RD1 = '0; RD2 = '0; immed = '0;
    rt = 5'd3; rd = 5'd9;
  endtask

  // Runs one multu/divu from presentation through the DONE hand-off.
  task automatic do_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    int n;
    clear_inputs();
    ALUop_in = 2'b10; funct = f; RD1 = a; RD2 = b; RegWrite_in = 1; RegDst_in = 1;
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      @(posedge clk); #1;
      n++;
      chk({name, " bubble ctrl"},
          {27'd0, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out}, 32'd0);
    end
    chk({name, " stall cycles"}, n, 32'd33);
    @(posedge clk); #1;
    chk({name, " held RegWrite_out"}, {31'd0, RegWrite_out}, 32'd0);
    chk({name, " held wrReg_out"}, {27'd0, wrReg_out}, 32'd9);
  endtask

  task automatic mf(input logic [5:0] f, input logic [31:0] exp, input string name);
    clear_inputs();
    ALUop_in = 2'b10; funct = f; RegWrite_in = 1; RegDst_in = 1;
    #1;
    chk({name, " stall_o"}, {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    chk({name, " result"}, ALUResult_out, exp);
    chk({name, " RegWrite_out"}, {31'd0, RegWrite_out}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            op     fn     sh  src dst rw br pc      a             b             imm           res           z  bt            wr
    vecs[0]  = mk(2'b10, 6'h20, 0,  0,  1,  1, 0, 32'h0,  32'd7,        32'd5,        32'h0,        32'd12,       0, 32'h0,        9);
    vecs[1]  = mk(2'b10, 6'h22, 0,  0,  1,  1, 0, 32'h0,  32'd5,        32'd5,        32'h0,        32'd0,        1, 32'h0,        9);
    vecs[2]  = mk(2'b10, 6'h2A, 0,  0,  1,  1, 0, 32'h0,  32'hFFFFFFFF, 32'd1,        32'h0,        32'd1,        0, 32'h0,        9);
    vecs[3]  = mk(2'b10, 6'h00, 31, 0,  1,  1, 0, 32'h0,  32'd0,        32'd1,        32'h0,        32'h80000000, 0, 32'h0,        9);
    vecs[4]  = mk(2'b01, 6'h00, 0,  0,  0,  0, 1, 32'h100,32'h55,       32'h55,       32'hFFFFFFFF, 32'd0,        1, 32'hFC,       3);
    vecs[5]  = mk(2'b10, 6'h24, 0,  0,  1,  1, 0, 32'h4,  32'hF0F0,     32'hFF00,     32'h1,        32'hF000,     0, 32'h8,        9);
    vecs[6]  = mk(2'b10, 6'h25, 0,  0,  1,  1, 0, 32'h0,  32'hF0F0,     32'hFF00,     32'h0,        32'hFFF0,     0, 32'h0,        9);
    vecs[7]  = mk(2'b10, 6'h02, 4,  0,  1,  1, 0, 32'h0,  32'h0,        32'h80000000, 32'h0,        32'h08000000, 0, 32'h0,        9);
    vecs[8]  = mk(2'b00, 6'h00, 0,  1,  0,  1, 0, 32'h0,  32'h10,       32'h0,        32'hFFFFFFFE, 32'hE,        0, 32'hFFFFFFF8, 3);
    vecs[9]  = mk(2'b11, 6'h00, 0,  1,  0,  1, 0, 32'h0,  32'h1200,     32'h0,        32'h34,       32'h1234,     0, 32'hD0,       3);
    vecs[10] = mk(2'b10, 6'h3F, 0,  0,  1,  1, 0, 32'h0,  32'd1,        32'd2,        32'h0,        32'd0,        1, 32'h0,        9);
    vecs[11] = mk(2'b10, 6'h20, 0,  0,  1,  1, 0, 32'h0,  32'hFFFFFFFF, 32'd1,        32'h0,        32'd0,        1, 32'h0,        9);
    vecs[12] = mk(2'b10, 6'h2A, 0,  0,  1,  1, 0, 32'h0,  32'd1,        32'hFFFFFFFF, 32'h0,        32'd0,        1, 32'h0,        9);
    vecs[13] = mk(2'b01, 6'h00, 0,  1,  0,  1, 0, 32'h0,  32'd9,        32'd77,       32'd4,        32'd5,        0, 32'h10,       3);

    // Reset with random inputs
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in, RegDst_in, ALUSrc_in} = 7'($urandom);
      ALUop_in = 2'($urandom); funct = 6'($urandom); shamt = 5'($urandom);
      RD1 = $urandom; RD2 = $urandom; immed = $urandom; pc_incr = $urandom;
      rt = 5'($urandom); rd = 5'($urandom);
      @(posedge clk); #1;
      chk("reset ctrl/zero", {26'd0, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
                              Branch_out, Zero_out}, 32'd0);
      chk("reset ALUResult_out", ALUResult_out, 32'd0);
      chk("reset btarget_out", btarget_out, 32'd0);
      chk("reset storeData_out", storeData_out, 32'd0);
      chk("reset wrReg_out", {27'd0, wrReg_out}, 32'd0);
      chk("reset stall_o", {31'd0, stall_o}, 32'd0);
    end
    rst = 1'b0;
    clear_inputs();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      ALUop_in = vecs[i].op; funct = vecs[i].fn; shamt = vecs[i].sh;
      ALUSrc_in = vecs[i].alusrc; RegDst_in = vecs[i].regdst;
      RegWrite_in = vecs[i].rw; Branch_in = vecs[i].br;
      MemtoReg_in = i[0]; MemRead_in = i[1]; MemWrite_in = i[2];
      pc_incr = vecs[i].pc; RD1 = vecs[i].a; RD2 = vecs[i].b; immed = vecs[i].imm;
      #1;
      chk($sformatf("vec%0d stall_o", i), {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d ALUResult_out", i), ALUResult_out, vecs[i].e_res);
      chk($sformatf("vec%0d Zero_out", i), {31'd0, Zero_out}, {31'd0, vecs[i].e_zero});
      chk($sformatf("vec%0d btarget_out", i), btarget_out, vecs[i].e_bt);
      chk($sformatf("vec%0d wrReg_out", i), {27'd0, wrReg_out}, {27'd0, vecs[i].e_wr});
      chk($sformatf("vec%0d storeData_out", i), storeData_out, vecs[i].b);
      chk($sformatf("vec%0d ctrl", i),
          {27'd0, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out},
          {27'd0, vecs[i].rw, i[0], i[1], i[2], vecs[i].br});
    end

    // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    do_md(6'h19, 32'hFFFFFFFF, 32'd2, "multu max*2");
    mf(6'h12, 32'hFFFFFFFE, "mflo after multu");
    mf(6'h10, 32'h00000001, "mfhi after multu");

    // divu 100/7 -> q 14 r 2
    do_md(6'h1B, 32'd100, 32'd7, "divu 100/7");
    mf(6'h12, 32'd14, "mflo after divu");
    mf(6'h10, 32'd2, "mfhi after divu");

    // divu by zero -> LO all ones, HI dividend
    do_md(6'h1B, 32'd9, 32'd0, "divu 9/0");
    mf(6'h12, 32'hFFFFFFFF, "mflo after divu0");
    mf(6'h10, 32'd9, "mfhi after divu0");

    // Back-to-back: multu then divu with no gap
    do_md(6'h19, 32'd6, 32'd7, "multu 6*7");
    do_md(6'h1B, 32'd100, 32'd10, "divu b2b 100/10");
    mf(6'h12, 32'd10, "mflo after b2b");
    mf(6'h10, 32'd0, "mfhi after b2b");

    // Reset in the 10th BUSY cycle of a multu
    clear_inputs();
    ALUop_in = 2'b10; funct = 6'h19; RD1 = 32'd3; RD2 = 32'd5; RegWrite_in = 1;
    #1;
    chk("abort start stall_o", {31'd0, stall_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("abort busy stall_o", {31'd0, stall_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort reset ctrl", {27'd0, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
                            Branch_out}, 32'd0);
    mf(6'h12, 32'd0, "mflo after abort");
    mf(6'h10, 32'd0, "mfhi after abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
